// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable generator: per-channel runtime divisor, single-cycle
// tick enable and registered square wave, with shared load/sync/enable/reset.

module clk_div_ch #(
  parameter int WIDTH   = 16,
  parameter int DIV_RST = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic             sync,
  input  logic [WIDTH-1:0] div_ld,
  output logic             tick,
  output logic             clk_out
);
  localparam logic [WIDTH-1:0] RST_D = WIDTH'(DIV_RST);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] div_q, cnt, div_d, cnt_d, dm1;
  logic             run, wrap;

  // D-1 only formed for a nonzero divisor so the compare never sees an underflow
  assign run  = (div_q != '0);
  assign dm1  = run ? (div_q - ONE) : '0;
  assign wrap = run && (cnt == dm1);
  assign tick = en & wrap;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt;
    if (clr) begin
      div_d = RST_D;
      cnt_d = '0;
    end else if (load) begin
      div_d = div_ld;
      cnt_d = '0;
    end else if (sync) begin
      cnt_d = '0;
    end else if (en && run) begin
      cnt_d = wrap ? '0 : (cnt + ONE);
    end
  end

  // clk_out registers the decode of the next state: low ceil(D/2), high floor(D/2)
  always_ff @(posedge clk) begin
    div_q   <= div_d;
    cnt     <= cnt_d;
    clk_out <= (div_d != '0) && (cnt_d >= (div_d - (div_d >> 1)));
  end
endmodule

module clk_div_multi #(
  parameter int WIDTH   = 16,
  parameter int NCH     = 2,
  parameter int DIV_RST = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 load,
  input  logic [NCH*WIDTH-1:0] div_in,
  input  logic                 sync,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       clk_out
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(
      .WIDTH   (WIDTH),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk     (clk),
      .clr     (clr),
      .en      (en),
      .load    (load),
      .sync    (sync),
      .div_ld  (div_in[i*WIDTH +: WIDTH]),
      .tick    (tick[i]),
      .clk_out (clk_out[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: a phase-count model predicts tick/clk_out
// each cycle; predictions go through a scoreboard queue and are compared at negedge.

module tb_clk_div_multi;
  localparam int WIDTH = 16;
  localparam int NCH   = 2;
  localparam int DIV_RST = 2;

  logic                 clk, clr, en, load, sync;
  logic [NCH*WIDTH-1:0] div_in;
  logic [NCH-1:0]       tick, clk_out;

  clk_div_multi #(.WIDTH(WIDTH), .NCH(NCH), .DIV_RST(DIV_RST)) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .load    (load),
    .div_in  (div_in),
    .sync    (sync),
    .tick    (tick),
    .clk_out (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    tag;
    logic [3:0] exp;   // {clk_out[1], clk_out[0], tick[1], tick[0]}
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // model: divisor and enabled-cycle count since the last restart
  int  md[NCH];
  int  mp[NCH];
  bit  mvalid = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] predict(input logic e);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      if (md[i] != 0) begin
        r[i]     = e && ((mp[i] % md[i]) == md[i] - 1);
        r[i + 2] = (mp[i] % md[i]) >= (md[i] + 1) / 2;
      end
    end
    return r;
  endfunction

  task automatic cyc(input logic e, input logic l, input logic s, input logic c,
                     input int d0, input int d1, input string tag);
    sb_t ent;
    en = e; load = l; sync = s; clr = c;
    div_in = {WIDTH'(d1), WIDTH'(d0)};
    if (mvalid) begin
      ent.tag = tag;
      ent.exp = predict(e);
      sbq.push_back(ent);
    end
    @(negedge clk);
    if (sbq.size() > 0) begin
      ent = sbq.pop_front();
      chk(ent.tag, {28'd0, clk_out, tick}, {28'd0, ent.exp});
    end
    @(posedge clk);
    if (c) begin
      md[0] = DIV_RST; md[1] = DIV_RST; mp[0] = 0; mp[1] = 0;
      mvalid = 1;
    end else if (l) begin
      md[0] = d0; md[1] = d1; mp[0] = 0; mp[1] = 0;
    end else if (s) begin
      mp[0] = 0; mp[1] = 0;
    end else if (e) begin
      for (int i = 0; i < NCH; i++) if (md[i] != 0) mp[i]++;
    end
    #1;
  endtask

  task automatic run(input int n, input logic e, input string tag);
    for (int k = 0; k < n; k++) cyc(e, 1'b0, 1'b0, 1'b0, 0, 0, tag);
  endtask

  initial begin
    en = 0; load = 0; sync = 0; clr = 0; div_in = '0;
    @(posedge clk); #1;

    // 1: reset then default divide-by-2
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, "t1_clr");
    run(8, 1'b1, "t1_div2");
    chk("t1_div2_phase", {30'd0, clk_out}, 32'd0);

    // 2: load 5 / 3
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5, 3, "t2_load");
    run(16, 1'b1, "t2_run");

    // 3: D=5, pause at cnt=2 for four cycles
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5, 5, "t3_load");
    run(2, 1'b1, "t3_pre");
    run(4, 1'b0, "t3_gap");
    run(8, 1'b1, "t3_post");

    // 4: 4 / 6 out of phase, then sync
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4, 6, "t4_load");
    run(7, 1'b1, "t4_pre");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, "t4_sync");
    run(13, 1'b1, "t4_post");

    // 5: stopped channel and divide-by-1
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1, "t5_load");
    for (int k = 0; k < 10; k++) cyc(logic'(k % 3 != 1), 1'b0, 1'b0, 1'b0, 0, 0, "t5_run");

    // 6: clr wins over simultaneous load
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 7, 7, "t6_load");
    run(3, 1'b1, "t6_pre");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 9, 9, "t6_clrload");
    run(6, 1'b1, "t6_post");

    // load with en low, then load+sync together
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3, 4, "x_load_en0");
    run(3, 1'b0, "x_hold");
    run(4, 1'b1, "x_go");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 6, 2, "x_loadsync");
    run(8, 1'b1, "x_run");

    // randomized enable / sync / load mix
    for (int k = 0; k < 80; k++) begin
      logic e, s, l;
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 19) == 0);
      cyc(e, l, s, 1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "rnd");
    end

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock-enable generator for the Pong video/game timing path. It generalises the fixed divide-by-2 pixel-clock divider into NCH independent channels. Each channel has a runtime-loadable divisor, a single-cycle `tick` enable and a registered square-wave `clk_out`. It sits directly after the board clock and feeds the VGA timing generator (25 MHz pixel enable) and the game-update logic (frame-rate ticks) as clock enables rather than derived clocks.

## Interface
- `WIDTH`, 16, bit width of each divisor and counter.
- `NCH`, 2, number of independent channels.
- `DIV_RST`, 2, divisor loaded into every channel at reset.

- `clk`  in  1  system clock; all logic on rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `en`  in  1  global count enable.
- `load`  in  1  one-cycle strobe; latch `div_in` into all channels.
- `div_in`  in  NCH*WIDTH  packed divisors; channel i = bits [i*WIDTH +: WIDTH].
- `sync`  in  1  one-cycle strobe; restart all counters at phase 0 without changing divisors.
- `tick`  out  NCH  per-channel clock-enable pulse, one cycle per period.
- `clk_out`  out  NCH  per-channel registered square wave.

## Operation
- Per-channel state: `div_q[i]` (WIDTH) and `cnt[i]` (WIDTH). Let D = `div_q[i]`.
- Update priority per cycle: `clr` > `load` > `sync` > `en` > hold.
  - `clr`: `div_q` <= DIV_RST, `cnt` <= 0, all channels.
  - `load`: `div_q` <= `div_in` slice, `cnt` <= 0, all channels. Takes effect regardless of `en`.
  - `sync`: `cnt` <= 0, all channels, with `div_q` unchanged.
  - `en`=1, D>=1: `cnt` <= (`cnt`==D-1) ? 0 : `cnt`+1.
  - `en`=0: `cnt` holds.
- D = 0: channel stopped. `cnt` held at 0, `tick`=0, `clk_out`=0.
- D = 1: `cnt` stays 0, `tick` = `en` every cycle, `clk_out` = 0.
- `tick[i]` = `en` & (D != 0) & (`cnt[i]` == D-1).
  - This is the only combinational path from an input to an output: one AND level from `en`.
  - `tick` coincides with the cycle in which the counter wraps.
- `clk_out[i]` is a flop loaded with (next `cnt` >= D - floor(D/2)) & (next D != 0).
  - The output therefore equals this decode of the current `cnt`/`div_q`, with no glitches.
  - Duty cycle: low for ceil(D/2) cycles, then high for floor(D/2) cycles.
  - With D=2 the output toggles every enabled cycle, which is exactly the legacy divide-by-2 behaviour.
- `clk_out` holds its value while `en`=0.
- Counter compare uses WIDTH-bit unsigned arithmetic. D-1 is computed only when D != 0, so no underflow.
- All channels share `load`, `sync`, `en` and `clr`. Channels are otherwise independent.

## Timing
- Reset values, in the cycle after `clr` is sampled high: `cnt`=0, `div_q`=DIV_RST, `clk_out`=0.
  - `tick`=0 for DIV_RST >= 2. `tick`=`en` for DIV_RST=1.
- Latency for `load` and `sync`: outputs reflect phase 0 with the new/kept D on the first cycle after the strobe.
- First `tick` after `load`/`sync`: D-1 enabled cycles later.
- Steady state: `tick` period = D enabled cycles. `clk_out` period = D enabled cycles.
- Simultaneous events:
  - `load` and `sync` in the same cycle behave as `load`.
  - `clr` with anything behaves as `clr`.
  - `load` while `en`=0 still loads, and the counter restarts at 0 but does not advance.
- Reset mid-period: counters abort immediately and no partial `tick` is issued.
- Divisor change mid-period: only possible via `load`, which always restarts phase. A count can therefore never exceed D-1.

## Test plan
1. `clr` 3 cycles then release, `en`=1, defaults (DIV_RST=2).
   - Required: both `clk_out` = 0,1,0,1,…
   - Required: `tick` high on every cycle where `clk_out`=1.
2. `load` with ch0=5, ch1=3, `en`=1.
   - ch0 required: `tick` on cycles 4, 9, 14 after the load. `clk_out` pattern 0,0,0,1,1 repeating.
   - ch1 required: `tick` every 3 cycles. `clk_out` pattern 0,0,1.
3. D=5, drop `en` for 4 cycles at `cnt`=2, then restore.
   - Required: `tick`=0 and `clk_out` frozen during the gap.
   - Required: the next `tick` arrives 2 enabled cycles after `en` returns.
4. ch0=4, ch1=6 running out of phase, pulse `sync`.
   - Required: both `cnt`=0 on the next cycle.
   - Required: first `tick`s at +3 (ch0) and +5 (ch1). Divisors unchanged.
5. `load` ch0=0, ch1=1.
   - Required for ch0: `tick`=0 and `clk_out`=0 indefinitely.
   - Required for ch1: `tick` follows `en` every cycle and `clk_out`=0.
6. Running at D=7, assert `clr` and `load` (ch0=9) in the same cycle.
   - Required: `div_q` = DIV_RST (not 9), `cnt`=0, `clk_out`=0 on the next cycle.
   - Required: D=2 toggling resumes afterwards.
